// File: rtl/four_input_adder_pkg.sv
// Shared types and helpers for the bit-serial four-operand adder.
//   state_e      : controller states (IDLE, CALC, DONE)
//   result_width : width of a four-operand sum of w-bit unsigned values (w+2)
package four_input_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned result_width(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/d_register.sv
// Plain D register with enable and synchronous active-high reset.
//   clk_in, rst_in : clock, synchronous reset (clears q_out)
//   en_in          : load d_in on the rising edge
//   d_in / q_out   : W-bit data in / registered data out
module d_register #(
    parameter int unsigned W = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         en_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_in) begin
            q_d = d_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: rtl/four_input_full_adder.sv
// Combinational six-input, one-bit-position adder cell.
//   a0_in..a3_in : operand bits (weight 1)
//   c0_in, c1_in : recirculated carries, both entering at weight 1
//   b_out        : sum bit (weight 1)
//   c0_out       : carry of weight 2
//   c1_out       : carry of weight 4
module four_input_full_adder (
    input  logic a0_in,
    input  logic a1_in,
    input  logic a2_in,
    input  logic a3_in,
    input  logic c0_in,
    input  logic c1_in,
    output logic b_out,
    output logic c0_out,
    output logic c1_out
);

    // At most six ones, so the count always fits in three bits.
    logic [2:0] total;

    always_comb begin
        total = 3'(a0_in) + 3'(a1_in) + 3'(a2_in) + 3'(a3_in)
              + 3'(c0_in) + 3'(c1_in);
        {c1_out, c0_out, b_out} = total;
    end

endmodule

// File: rtl/four_input_serial_adder.sv
// Bit-serial sum of four WIDTH-bit unsigned operands, LSB first, one bit
// position per clock through a single four_input_full_adder cell.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   valid_in / ready_out  : operand handshake (ready_out high only in IDLE)
//   a0_in..a3_in          : operands, captured on accept
//   sum_out / valid_out   : WIDTH+2-bit result, held until ready_in
//   ready_in              : downstream consumes the result
module four_input_serial_adder
    import four_input_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a0_in,
    input  logic [WIDTH-1:0] a1_in,
    input  logic [WIDTH-1:0] a2_in,
    input  logic [WIDTH-1:0] a3_in,
    output logic [WIDTH+1:0] sum_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int unsigned RES_W = result_width(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a0_q, a0_d, a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   sum_q, sum_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic accept;
    logic calc;
    logic carry_en;
    logic c0_d, c0_q;
    logic c1_s1_d, c1_s1_q;
    logic c1_s2_d, c1_s2_q;
    logic cell_b, cell_c0, cell_c1;

    // c0 (weight 2) re-enters one position up; c1 (weight 4) two positions up.
    four_input_full_adder u_cell (
        .a0_in  (a0_q[0]),
        .a1_in  (a1_q[0]),
        .a2_in  (a2_q[0]),
        .a3_in  (a3_q[0]),
        .c0_in  (c0_q),
        .c1_in  (c1_s2_q),
        .b_out  (cell_b),
        .c0_out (cell_c0),
        .c1_out (cell_c1)
    );

    d_register #(.W(1)) u_c0_reg (
        .clk_in (clk_in), .rst_in (rst_in), .en_in (carry_en),
        .d_in   (c0_d),   .q_out  (c0_q)
    );

    d_register #(.W(1)) u_c1_s1_reg (
        .clk_in (clk_in), .rst_in (rst_in), .en_in (carry_en),
        .d_in   (c1_s1_d), .q_out (c1_s1_q)
    );

    d_register #(.W(1)) u_c1_s2_reg (
        .clk_in (clk_in), .rst_in (rst_in), .en_in (carry_en),
        .d_in   (c1_s2_d), .q_out (c1_s2_q)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        accept  = 1'b0;
        calc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    accept  = 1'b1;
                    a0_d    = a0_in;
                    a1_d    = a1_in;
                    a2_d    = a2_in;
                    a3_d    = a3_in;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc  = 1'b1;
                sum_d = {cell_b, sum_q[RES_W-1:1]};
                a0_d  = a0_q >> 1;
                a1_d  = a1_q >> 1;
                a2_d  = a2_q >> 1;
                a3_d  = a3_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH + 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept clears the carry chain; CALC advances it.
        carry_en = accept | calc;
        c0_d     = calc ? cell_c0 : 1'b0;
        c1_s1_d  = calc ? cell_c1 : 1'b0;
        c1_s2_d  = calc ? c1_s1_q : 1'b0;

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            a0_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_four_input_serial_adder.sv
// Bench for four_input_serial_adder at WIDTH=8 and WIDTH=1. Expected sums
// come from plain integer addition of the operands.
module tb_four_input_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=8 instance signals
    logic       v_in8 = 1'b0, rdy_in8 = 1'b0;
    logic       rdy_out8, v_out8;
    logic [7:0] a0_8 = '0, a1_8 = '0, a2_8 = '0, a3_8 = '0;
    logic [9:0] sum8;

    // WIDTH=1 instance signals
    logic       v_in1 = 1'b0, rdy_in1 = 1'b0;
    logic       rdy_out1, v_out1;
    logic [0:0] a0_1 = '0, a1_1 = '0, a2_1 = '0, a3_1 = '0;
    logic [2:0] sum1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    four_input_serial_adder #(.WIDTH(8)) dut8 (
        .clk_in (clk), .rst_in (rst), .valid_in (v_in8), .ready_out (rdy_out8),
        .a0_in (a0_8), .a1_in (a1_8), .a2_in (a2_8), .a3_in (a3_8),
        .sum_out (sum8), .valid_out (v_out8), .ready_in (rdy_in8)
    );

    four_input_serial_adder #(.WIDTH(1)) dut1 (
        .clk_in (clk), .rst_in (rst), .valid_in (v_in1), .ready_out (rdy_out1),
        .a0_in (a0_1), .a1_in (a1_1), .a2_in (a2_1), .a3_in (a3_1),
        .sum_out (sum1), .valid_out (v_out1), .ready_in (rdy_in1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One WIDTH=8 operation; expects DONE after 10 edges, then handshakes.
    task automatic op8(input int x0, input int x1, input int x2, input int x3,
                       input logic tie_ready, input string tag);
        int lat;
        int exp_sum;
        exp_sum = x0 + x1 + x2 + x3;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(rdy_out8), 32'd1);
        a0_8 = 8'(x0); a1_8 = 8'(x1); a2_8 = 8'(x2); a3_8 = 8'(x3);
        v_in8 = 1'b1;
        rdy_in8 = tie_ready;
        @(posedge clk);
        @(negedge clk);
        v_in8 = 1'b0;
        chk({tag, "_ready_busy"}, 32'(rdy_out8), 32'd0);
        lat = 0;
        while (!v_out8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd10);
        chk({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
        rdy_in8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(v_out8), 32'd0);
        chk({tag, "_ready_back"}, 32'(rdy_out8), 32'd1);
        chk({tag, "_sum_held"}, 32'(sum8), 32'(exp_sum));
        rdy_in8 = tie_ready;
    endtask

    task automatic op1(input int x0, input int x1, input int x2, input int x3, input string tag);
        int lat;
        @(negedge clk);
        a0_1 = 1'(x0); a1_1 = 1'(x1); a2_1 = 1'(x2); a3_1 = 1'(x3);
        v_in1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_in1 = 1'b0;
        lat = 0;
        while (!v_out1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_sum"}, 32'(sum1), 32'(x0 + x1 + x2 + x3));
        rdy_in1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_in1 = 1'b0;
        chk({tag, "_ready_back"}, 32'(rdy_out1), 32'd1);
    endtask

    initial begin
        int r0, r1, r2, r3, seen;

        // Reset state of both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready8", 32'(rdy_out8), 32'd1);
        chk("rst_valid8", 32'(v_out8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_ready1", 32'(rdy_out1), 32'd1);
        chk("rst_valid1", 32'(v_out1), 32'd0);

        // Directed cases
        op8(1, 2, 3, 4, 1'b0, "d1234");
        op8(255, 255, 255, 255, 1'b0, "dmax");
        op8(255, 1, 0, 0, 1'b0, "dripple");
        op8(0, 0, 0, 0, 1'b0, "dzero");

        // Backpressure: hold ready_in low in DONE while offering new operands
        @(negedge clk);
        a0_8 = 8'd7; a1_8 = 8'd8; a2_8 = 8'd9; a3_8 = 8'd10;
        v_in8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_in8 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_valid_up", 32'(v_out8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a0_8 = 8'(i + 50); a1_8 = 8'd1; a2_8 = 8'd1; a3_8 = 8'd1;
            v_in8 = ~v_in8;
            @(posedge clk);
            @(negedge clk);
            chk("bp_sum", 32'(sum8), 32'd34);
            chk("bp_valid", 32'(v_out8), 32'd1);
            chk("bp_ready", 32'(rdy_out8), 32'd0);
        end
        v_in8 = 1'b0;
        rdy_in8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_in8 = 1'b0;
        chk("bp_idle_ready", 32'(rdy_out8), 32'd1);
        chk("bp_idle_valid", 32'(v_out8), 32'd0);
        chk("bp_idle_sum", 32'(sum8), 32'd34);

        // Reset during the fourth CALC cycle aborts the operation
        a0_8 = 8'd200; a1_8 = 8'd199; a2_8 = 8'd255; a3_8 = 8'd171;
        v_in8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_in8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(rdy_out8), 32'd1);
        chk("abort_sum", 32'(sum8), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (v_out8) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        op8(10, 20, 30, 40, 1'b0, "post_rst");

        // Randomized operands, some with ready_in tied high
        for (int i = 0; i < 16; i++) begin
            r0 = int'($urandom_range(255));
            r1 = int'($urandom_range(255));
            r2 = int'($urandom_range(255));
            r3 = int'($urandom_range(255));
            op8(r0, r1, r2, r3, 1'(i % 2), "rand8");
        end

        // WIDTH=1 instance
        op1(1, 1, 1, 1, "w1_all");
        for (int i = 0; i < 6; i++) begin
            op1(int'($urandom_range(1)), int'($urandom_range(1)),
                int'($urandom_range(1)), int'($urandom_range(1)), "w1_rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
